// File: rtl/sigdel_pkg.sv
// Shared constants and helpers for the sigma-delta CIC decimator.
// Define SIGDEL_SINC3_EN to build a sinc3 filter instead of the default sinc2.
package sigdel_pkg;
`ifdef SIGDEL_SINC3_EN
   localparam int CIC_ORDER = 3;
`else
   localparam int CIC_ORDER = 2;
`endif

   function automatic int cic_width(input int order, input int log2r);
      return order * log2r + 1;
   endfunction

   // Negative result means the raw comb output must be shifted up, not down.
   function automatic int cic_shift(input int order, input int log2r, input int out_w);
      return order * log2r - out_w;
   endfunction

   typedef enum logic {SETTLING, RUN} settle_state_t;
endpackage

// File: rtl/sigdel_comb.sv
// One CIC differentiator stage: delay register captured on each decimation tick.
module sigdel_comb #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         tick,
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);
   logic [W-1:0] x_dly;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)    x_dly <= '0;
      else if (tick) x_dly <= x;

   assign y = x - x_dly;
endmodule

// File: rtl/sigdel_decim.sv
// CIC decimator turning a 1-bit density stream into OUT_W-bit samples.
// SIGDEL_SINC3_EN selects order 3; default build is order 2.
module sigdel_decim
   import sigdel_pkg::*;
#(
   parameter int DECIM_LOG2 = 5,
   parameter int OUT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             bit_in,
   output logic [OUT_W-1:0] dout,
   output logic             dout_valid,
   output logic             settled
);
   localparam int N  = CIC_ORDER;
   localparam int W  = cic_width(N, DECIM_LOG2);
   localparam int SH = cic_shift(N, DECIM_LOG2, OUT_W);
   localparam int SW = W + OUT_W;
   localparam logic [SW-1:0] SMAX = SW'((1 << OUT_W) - 1);

   logic [1:0]            sync;
   logic [N-1:0][W-1:0]   integ;
   logic [DECIM_LOG2-1:0] phase;
   logic                  tick;
   logic [N:0][W-1:0]     cx;
   logic [SW-1:0]         r_ext, s;
   logic [OUT_W-1:0]      dout_nxt;
   settle_state_t         state, state_nxt;
   logic [1:0]            scnt, scnt_nxt;
   logic                  emit;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync <= '0;
      else        sync <= {sync[0], bit_in};

   // Integrators wrap modulo 2^W; the comb differences undo the wrap.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         integ <= '0;
      end else if (en) begin
         integ[0] <= integ[0] + {{(W-1){1'b0}}, sync[1]};
         for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)  phase <= '0;
      else if (en) phase <= phase + 1'b1;

   assign tick  = en & (&phase);
   assign cx[0] = integ[N-1];

   for (genvar g = 0; g < N; g++) begin : g_comb
      sigdel_comb #(.W(W)) u_comb (
         .clk  (clk),
         .rst_n(rst_n),
         .tick (tick),
         .x    (cx[g]),
         .y    (cx[g+1])
      );
   end

   assign r_ext = {{OUT_W{1'b0}}, cx[N]};
   if (SH >= 0) begin : g_shr
      assign s = r_ext >> SH;
   end else begin : g_shl
      assign s = r_ext << (-SH);
   end
   assign dout_nxt = (s > SMAX) ? '1 : s[OUT_W-1:0];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= SETTLING;
         scnt  <= '0;
      end else begin
         state <= state_nxt;
         scnt  <= scnt_nxt;
      end

   // The first N tick results are discarded; tick N+1 is the first one emitted.
   always_comb begin
      state_nxt = state;
      scnt_nxt  = scnt;
      emit      = 1'b0;
      case (state)
         SETTLING:
            if (tick) begin
               if (scnt == 2'(N)) begin
                  state_nxt = RUN;
                  emit      = 1'b1;
               end else begin
                  scnt_nxt = scnt + 1'b1;
               end
            end
         RUN:     emit = tick;
         default: state_nxt = SETTLING;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= emit;
         if (emit) dout <= dout_nxt;
      end

   assign settled = (state == RUN);
endmodule

// File: tb/tb_sigdel_decim.sv
// Directed bench for sigdel_decim in either filter order.
module tb_sigdel_decim;
`ifdef SIGDEL_SINC3_EN
   localparam int N = 3;
`else
   localparam int N = 2;
`endif
   localparam int R = 32;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       bit_in = 1'b0;
   logic [7:0] dout;
   logic       dout_valid;
   logic       settled;

   int checks = 0;
   int errors = 0;

   int         pulse_cyc[$];
   logic [7:0] pulse_dout[$];
   logic       pulse_set[$];
   int         pre_bad;

   sigdel_decim dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .bit_in    (bit_in),
      .dout      (dout),
      .dout_valid(dout_valid),
      .settled   (settled)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n  = 1'b0;
      en     = 1'b0;
      bit_in = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   // mode: 0 zeros, 1 ones, 2 alternating, 3 density 3/4, 4 looped-back modulator at 64.
   // The pattern only advances for bits that will actually be integrated, so the
   // integrated sequence stays periodic across an enable gap.
   task automatic run(input int mode, input int nsteps, input int gs, input int gl);
      int         idx;
      logic [7:0] macc;
      logic [8:0] sum;
      logic       b;
      pulse_cyc.delete();
      pulse_dout.delete();
      pulse_set.delete();
      pre_bad = 0;
      idx     = 0;
      macc    = 8'd0;
      for (int c = 0; c < nsteps; c++) begin
         en  = !(c >= gs && c < gs + gl);
         sum = {1'b0, macc} + 9'd64;
         case (mode)
            0:       b = 1'b0;
            1:       b = 1'b1;
            2:       b = (idx % 2 == 0);
            3:       b = (idx % 4 != 3);
            default: b = sum[8];
         endcase
         bit_in = b;
         if (!((c + 2) >= gs && (c + 2) < gs + gl)) begin
            idx++;
            macc = sum[7:0];
         end
         @(posedge clk);
         #1;
         if (dout_valid === 1'b1) begin
            pulse_cyc.push_back(c + 1);
            pulse_dout.push_back(dout);
            pulse_set.push_back(settled);
         end
         if (settled !== 1'b1 && (dout !== 8'd0 || dout_valid !== 1'b0)) pre_bad++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (dout !== 8'd0) begin errors++; $display("FAIL reset_dout got %0d want 0", dout); end
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dout_valid); end
      checks++;
      if (settled !== 1'b0) begin errors++; $display("FAIL reset_settled got %b want 0", settled); end
   endtask

   // Constant-input style runs: first pulse after N+1 ticks, then exactly every R clocks.
   task automatic check_stream(input string name, input int npulse, input int want, input int tol);
      int d;
      checks++;
      if (pulse_cyc.size() != npulse) begin
         errors++;
         $display("FAIL %s_count got %0d want %0d", name, pulse_cyc.size(), npulse);
      end
      checks++;
      if (pre_bad !== 0) begin errors++; $display("FAIL %s_presettle got %0d bad cycles want 0", name, pre_bad); end
      if (pulse_cyc.size() > 0) begin
         checks++;
         if (pulse_cyc[0] !== (N + 1) * R) begin
            errors++;
            $display("FAIL %s_first got %0d want %0d", name, pulse_cyc[0], (N + 1) * R);
         end
      end
      for (int i = 0; i < pulse_cyc.size(); i++) begin
         d = int'(pulse_dout[i]) - want;
         checks++;
         if (d > tol || d < -tol) begin
            errors++;
            $display("FAIL %s_dout[%0d] got %0d want %0d", name, i, pulse_dout[i], want);
         end
         checks++;
         if (pulse_set[i] !== 1'b1) begin errors++; $display("FAIL %s_settled[%0d] got %b want 1", name, i, pulse_set[i]); end
         if (i > 0) begin
            checks++;
            if (pulse_cyc[i] - pulse_cyc[i-1] !== R) begin
               errors++;
               $display("FAIL %s_spacing[%0d] got %0d want %0d", name, i, pulse_cyc[i] - pulse_cyc[i-1], R);
            end
         end
      end
   endtask

   task automatic test_zero_density();
      do_reset();
      run(0, (N + 4) * R + 5, 0, 0);
      check_stream("zero", 4, 0, 0);
   endtask

   task automatic test_full_density();
      do_reset();
      run(1, (N + 4) * R + 5, 0, 0);
      check_stream("full", 4, 255, 0);
   endtask

   task automatic test_alternating();
      do_reset();
      run(2, (N + 4) * R + 5, 0, 0);
      check_stream("alt", 4, 128, 0);
      do_reset();
      run(4, (N + 4) * R + 5, 0, 0);
      check_stream("mod64", 4, 64, 1);
   endtask

   task automatic test_enable_gap();
      int exp_cyc[5];
      exp_cyc = '{(N + 1) * R, (N + 2) * R, (N + 3) * R + 7, (N + 4) * R + 7, (N + 5) * R + 7};
      do_reset();
      run(3, (N + 5) * R + 20, (N + 2) * R + 10, 7);
      checks++;
      if (pulse_cyc.size() != 5) begin errors++; $display("FAIL gap_count got %0d want 5", pulse_cyc.size()); end
      for (int i = 0; i < 5 && i < pulse_cyc.size(); i++) begin
         checks++;
         if (pulse_cyc[i] !== exp_cyc[i]) begin
            errors++;
            $display("FAIL gap_cyc[%0d] got %0d want %0d", i, pulse_cyc[i], exp_cyc[i]);
         end
         checks++;
         if (pulse_dout[i] !== 8'd192) begin
            errors++;
            $display("FAIL gap_dout[%0d] got %0d want 192", i, pulse_dout[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      run(1, (N + 1) * R + 40, 0, 0);
      checks++;
      if (settled !== 1'b1 || dout !== 8'd255) begin
         errors++;
         $display("FAIL arst_pre got settled=%b dout=%0d want settled=1 dout=255", settled, dout);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dout !== 8'd0) begin errors++; $display("FAIL arst_dout got %0d want 0", dout); end
      checks++;
      if (settled !== 1'b0) begin errors++; $display("FAIL arst_settled got %b want 0", settled); end
      checks++;
      if (dout_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", dout_valid); end
      @(posedge clk);
      #3 rst_n = 1'b1;
      run(1, (N + 2) * R + 5, 0, 0);
      check_stream("arst_resettle", 2, 255, 0);
   endtask

   initial begin
      test_reset();
      test_zero_density();
      test_full_density();
      test_alternating();
      test_enable_gap();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
